// File: rtl/ppu_regif_if.sv
`default_nettype none
// ============================================================================
// Module   : ppu_regif_if
// Purpose  : CPU bus bundle between the CPU core and the PPU register block.
//            One-cycle access strobe with address, direction and write data
//            from the CPU side, and combinational read data back.
// Signals  : bus_valid  - access strobe, address/data valid this cycle
//            bus_addr   - 16-bit CPU address
//            bus_wn     - 0 = write, 1 = read
//            bus_wdata  - write data
//            ppu_rdata  - read data (combinational in the access cycle)
// Modports : master (CPU side), slave (PPU register block)
// Revision : 1.0 - initial release
// ============================================================================
interface ppu_regif_if;
  logic        bus_valid;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic [7:0]  ppu_rdata;

  modport master (output bus_valid, bus_addr, bus_wn, bus_wdata, input ppu_rdata);
  modport slave  (input bus_valid, bus_addr, bus_wn, bus_wdata, output ppu_rdata);
endinterface
`default_nettype wire

// File: rtl/ppu_regif.sv
`default_nettype none
// ============================================================================
// Module   : ppu_regif
// Purpose  : CPU-side PPU register interface. Decodes $2000-$2007 (mirrored
//            through $3FFF) and $4014. Holds loopy T/V/fine-X/w, open-bus
//            latch, vblank flag with read-clear and suppression, level NMI,
//            and an OAM DMA engine that halts the CPU for one page copy.
// Ports    : i_cpu_clk/i_cpu_rstn - clock, async active-low reset
//            bus                  - CPU access bundle (slave modport)
//            o_dma_*/i_dma_rdata  - DMA halt request and source read port
//            o_oam_*/i_oam_rdata  - OAM access port
//            o_vram_*/i_vram_rdata- VRAM access port, o_2007_visit strobe
//            o_ppuctrl/o_ppumask/o_loopy_t/o_fine_x/o_force_rld - render core
//            i_spr_ovfl/i_spr_0hit/i_vblank - status from render core
//            o_nmi_n              - NMI, active low
// Revision : 1.0 - initial release
// ============================================================================
module ppu_regif #(
  parameter int VADDR_W = 14,
  parameter int OAM_AW  = 8,
  parameter bit DMA_EN  = 1'b1
) (
  input  logic               i_cpu_clk,
  input  logic               i_cpu_rstn,
  ppu_regif_if.slave         bus,
  output logic               o_dma_halt,
  output logic [15:0]        o_dma_addr,
  input  logic [7:0]         i_dma_rdata,
  output logic [OAM_AW-1:0]  o_oam_addr,
  output logic               o_oam_we,
  output logic [7:0]         o_oam_wdata,
  input  logic [7:0]         i_oam_rdata,
  output logic [VADDR_W-1:0] o_vram_addr,
  output logic               o_vram_we,
  output logic [7:0]         o_vram_wdata,
  input  logic [7:0]         i_vram_rdata,
  output logic               o_2007_visit,
  output logic [7:0]         o_ppuctrl,
  output logic [7:0]         o_ppumask,
  output logic [14:0]        o_loopy_t,
  output logic [2:0]         o_fine_x,
  output logic               o_force_rld,
  input  logic               i_spr_ovfl,
  input  logic               i_spr_0hit,
  input  logic               i_vblank,
  output logic               o_nmi_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4
  } dma_state_t;

  dma_state_t        state_q, state_d;
  logic [7:2]        ctrl_q, ctrl_d;     // bits [1:0] live in T[11:10]
  logic [7:0]        mask_q, mask_d;
  logic [OAM_AW-1:0] oamaddr_q, oamaddr_d;
  logic [14:0]       t_q, t_d, v_q, v_d;
  logic [2:0]        fx_q, fx_d;
  logic              w_q, w_d;
  logic [7:0]        buf_q, buf_d, lat_q, lat_d;
  logic              flag_q, flag_d, vbl_q;
  logic              par_q, align_q, align_d;
  logic [7:0]        cnt_q, cnt_d, page_q, page_d;

  logic       w_halt, w_ppu_sel, w_wr, w_rd, w_dma_wr, w_rise, w_fall;
  logic [2:0] w_idx;

  assign w_halt    = (state_q != S_IDLE);
  assign w_ppu_sel = bus.bus_valid && !w_halt && (bus.bus_addr[15:13] == 3'b001);
  assign w_idx     = bus.bus_addr[2:0];
  assign w_wr      = w_ppu_sel && !bus.bus_wn;
  assign w_rd      = w_ppu_sel && bus.bus_wn;
  assign w_dma_wr  = DMA_EN && bus.bus_valid && !w_halt && !bus.bus_wn
                     && (bus.bus_addr == 16'h4014);
  assign w_rise    = i_vblank && !vbl_q;
  assign w_fall    = !i_vblank && vbl_q;

  // Outputs
  assign o_dma_halt   = w_halt;
  assign o_dma_addr   = (state_q == S_RD) ? {page_q, cnt_q} : 16'h0000;
  assign o_oam_addr   = oamaddr_q;
  assign o_oam_we     = (w_wr && w_idx == 3'd4) || (state_q == S_WR);
  assign o_oam_wdata  = (state_q == S_WR) ? i_dma_rdata : bus.bus_wdata;
  assign o_vram_addr  = v_q[VADDR_W-1:0];
  assign o_vram_we    = w_wr && (w_idx == 3'd7);
  assign o_vram_wdata = bus.bus_wdata;
  assign o_2007_visit = w_ppu_sel && (w_idx == 3'd7);
  assign o_ppuctrl    = {ctrl_q, t_q[11:10]};
  assign o_ppumask    = mask_q;
  assign o_loopy_t    = t_q;
  assign o_fine_x     = fx_q;
  assign o_force_rld  = w_wr && (w_idx == 3'd6) && w_q;
  assign o_nmi_n      = ~(flag_q & ctrl_q[7]);

  // Read data mux; palette reads bypass the buffer but keep open-bus top bits
  always_comb begin
    bus.ppu_rdata = 8'h00;
    if (w_rd) begin
      case (w_idx)
        3'd2:    bus.ppu_rdata = {flag_q, i_spr_0hit, i_spr_ovfl, lat_q[4:0]};
        3'd4:    bus.ppu_rdata = i_oam_rdata;
        3'd7:    bus.ppu_rdata = (v_q[13:8] == 6'h3F) ? {lat_q[7:6], i_vram_rdata[5:0]}
                                                       : buf_q;
        default: bus.ppu_rdata = lat_q;
      endcase
    end
  end

  // Next-state: register file, loopy state, vblank flag and DMA FSM
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    oamaddr_d = oamaddr_q;
    t_d       = t_q;
    v_d       = v_q;
    fx_d      = fx_q;
    w_d       = w_q;
    buf_d     = buf_q;
    lat_d     = lat_q;
    flag_d    = flag_q;
    align_d   = align_q;
    cnt_d     = cnt_q;
    page_d    = page_q;

    if (w_wr) begin
      lat_d = bus.bus_wdata;
      case (w_idx)
        3'd0: begin
          ctrl_d      = bus.bus_wdata[7:2];
          t_d[11:10]  = bus.bus_wdata[1:0];
        end
        3'd1: mask_d    = bus.bus_wdata;
        3'd3: oamaddr_d = OAM_AW'(bus.bus_wdata);
        3'd4: oamaddr_d = oamaddr_q + 1'b1;
        3'd5: begin
          w_d = ~w_q;
          if (!w_q) begin
            t_d[4:0] = bus.bus_wdata[7:3];
            fx_d     = bus.bus_wdata[2:0];
          end else begin
            t_d[9:5]   = bus.bus_wdata[7:3];
            t_d[14:12] = bus.bus_wdata[2:0];
          end
        end
        3'd6: begin
          w_d = ~w_q;
          if (!w_q) begin
            t_d[13:8] = bus.bus_wdata[5:0];
            t_d[14]   = 1'b0;
          end else begin
            t_d[7:0] = bus.bus_wdata;
            v_d      = {t_q[14:8], bus.bus_wdata};
          end
        end
        default: ;
      endcase
    end

    // Any $2007 access advances V; reads also refill the buffer
    if (w_ppu_sel && w_idx == 3'd7) begin
      v_d = v_q + (ctrl_q[2] ? 15'd32 : 15'd1);
      if (bus.bus_wn) buf_d = i_vram_rdata;
    end

    // Read-clear is applied last so a coincident rising edge is suppressed
    if (w_rise) flag_d = 1'b1;
    if (w_fall) flag_d = 1'b0;
    if (w_rd && w_idx == 3'd2) begin
      flag_d = 1'b0;
      w_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_dma_wr) begin
          state_d = S_HALT;
          page_d  = bus.bus_wdata;
          align_d = par_q;
          cnt_d   = 8'h00;
        end
      end
      S_HALT:  state_d = align_q ? S_ALIGN : S_RD;
      S_ALIGN: state_d = S_RD;
      S_RD:    state_d = S_WR;
      S_WR: begin
        oamaddr_d = oamaddr_q + 1'b1;
        cnt_d     = cnt_q + 8'd1;
        state_d   = (cnt_q == 8'hFF) ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      mask_q    <= '0;
      oamaddr_q <= '0;
      t_q       <= '0;
      v_q       <= '0;
      fx_q      <= '0;
      w_q       <= 1'b0;
      buf_q     <= '0;
      lat_q     <= '0;
      flag_q    <= 1'b0;
      vbl_q     <= 1'b0;
      par_q     <= 1'b0;
      align_q   <= 1'b0;
      cnt_q     <= '0;
      page_q    <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      oamaddr_q <= oamaddr_d;
      t_q       <= t_d;
      v_q       <= v_d;
      fx_q      <= fx_d;
      w_q       <= w_d;
      buf_q     <= buf_d;
      lat_q     <= lat_d;
      flag_q    <= flag_d;
      vbl_q     <= i_vblank;
      par_q     <= ~par_q;
      align_q   <= align_d;
      cnt_q     <= cnt_d;
      page_q    <= page_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_regif
// Purpose  : Self-checking bench for ppu_regif. Stimulus pushes expected
//            values into a scoreboard queue; a monitor pops and compares on
//            every bus read or probe request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_regif;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ppu_regif_if bif ();

  logic        dma_halt, oam_we, vram_we, visit, force_rld, nmi_n;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata, oam_wdata, oam_rdata, vram_wdata, vram_rdata;
  logic [7:0]  oam_addr, ppuctrl, ppumask;
  logic [13:0] vram_addr;
  logic [14:0] loopy_t;
  logic [2:0]  fine_x;
  logic        spr_ovfl, spr_0hit, vblank;

  ppu_regif #(.VADDR_W(14), .OAM_AW(8), .DMA_EN(1'b1)) dut (
    .i_cpu_clk(clk), .i_cpu_rstn(rstn), .bus(bif),
    .o_dma_halt(dma_halt), .o_dma_addr(dma_addr), .i_dma_rdata(dma_rdata),
    .o_oam_addr(oam_addr), .o_oam_we(oam_we), .o_oam_wdata(oam_wdata),
    .i_oam_rdata(oam_rdata), .o_vram_addr(vram_addr), .o_vram_we(vram_we),
    .o_vram_wdata(vram_wdata), .i_vram_rdata(vram_rdata), .o_2007_visit(visit),
    .o_ppuctrl(ppuctrl), .o_ppumask(ppumask), .o_loopy_t(loopy_t),
    .o_fine_x(fine_x), .o_force_rld(force_rld), .i_spr_ovfl(spr_ovfl),
    .i_spr_0hit(spr_0hit), .i_vblank(vblank), .o_nmi_n(nmi_n)
  );

  // Memory models: OAM array, DMA source page $02 (byte = addr[7:0]^$A5),
  // VRAM read data as a simple function of the address.
  logic [7:0] oam_mem [256];
  always @(posedge clk) if (oam_we) oam_mem[oam_addr] <= oam_wdata;
  always @(posedge clk)
    dma_rdata <= (dma_addr[15:8] == 8'h02) ? (dma_addr[7:0] ^ 8'hA5) : 8'h00;
  assign oam_rdata  = oam_mem[oam_addr];
  assign vram_rdata = vram_addr[7:0] ^ 8'h3C;

  // Independent cycle-parity model and event counters
  logic p;
  always @(posedge clk or negedge rstn) if (!rstn) p <= 1'b0; else p <= ~p;
  int hcnt = 0, fcnt = 0, hbase = 0, fbase = 0;
  always @(negedge clk) begin
    if (dma_halt)  hcnt++;
    if (force_rld) fcnt++;
  end

  typedef struct { string name; int sel; int idx; int expv; } exp_t;
  exp_t sbq[$];
  logic chk = 1'b0;
  int checks = 0, errors = 0;

  function automatic int probe(input int sel, input int idx);
    case (sel)
      1:  return int'(vram_addr);
      2:  return int'(loopy_t);
      3:  return int'(fine_x);
      4:  return int'(nmi_n);
      5:  return int'(dma_halt);
      6:  return int'(oam_addr);
      7:  return int'(ppuctrl);
      8:  return fcnt - fbase;
      9:  return hcnt - hbase;
      10: return int'(oam_mem[idx[7:0]]);
      default: return -1;
    endcase
  endfunction

  // Monitor: one pop per bus read or probe request
  always @(negedge clk) begin : mon
    exp_t e;
    int   act;
    if ((bif.bus_valid && bif.bus_wn) || chk) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_empty actual=unexpected_event required=queued_expectation");
      end else begin
        e = sbq.pop_front();
        act = (e.sel == 0) ? int'(bif.ppu_rdata) : probe(e.sel, e.idx);
        if (act != e.expv) begin
          errors++;
          $display("FAIL %s actual=%0h required=%0h", e.name, act, e.expv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bif.bus_valid = 1'b1; bif.bus_addr = a; bif.bus_wn = 1'b0; bif.bus_wdata = d;
    tick();
    bif.bus_valid = 1'b0; bif.bus_wdata = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a, input int expv, input string n);
    sbq.push_back('{name: n, sel: 0, idx: 0, expv: expv});
    bif.bus_valid = 1'b1; bif.bus_addr = a; bif.bus_wn = 1'b1;
    tick();
    bif.bus_valid = 1'b0; bif.bus_wn = 1'b0;
  endtask

  task automatic chkv(input string n, input int sel, input int idx, input int expv);
    sbq.push_back('{name: n, sel: sel, idx: idx, expv: expv});
    chk = 1'b1;
    tick();
    chk = 1'b0;
  endtask

  task automatic wait_dma_done();
    for (int i = 0; i < 600 && dma_halt; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.bus_valid = 1'b0; bif.bus_addr = 16'h0000; bif.bus_wn = 1'b0; bif.bus_wdata = 8'h00;
    vblank = 1'b0; spr_ovfl = 1'b0; spr_0hit = 1'b0;
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    chkv("rst_nmi_n", 4, 0, 1);
    chkv("rst_halt", 5, 0, 0);
    chkv("rst_v", 1, 0, 0);
    chkv("rst_t", 2, 0, 0);
    chkv("rst_ctrl", 7, 0, 0);
    rd(16'h2002, 8'h00, "rst_status");

    // $2006 load, $2007 buffered reads with +32 increment
    fbase = fcnt;
    wr(16'h2006, 8'h21);
    wr(16'h2006, 8'h08);
    chkv("force_rld_once", 8, 0, 1);
    chkv("v_2108", 1, 0, 16'h2108);
    chkv("t_2108", 2, 0, 16'h2108);
    wr(16'h2000, 8'h04);
    chkv("ctrl_04", 7, 0, 8'h04);
    rd(16'h2007, 8'h00, "rd2007_first");
    chkv("v_2128", 1, 0, 16'h2128);
    rd(16'h2007, 8'h34, "rd2007_second");
    chkv("v_2148", 1, 0, 16'h2148);
    rd(16'h2007, 8'h14, "rd2007_third");
    rd(16'h3FF8, 8'h04, "openbus_2000_mirror");

    // Palette read bypasses the buffer, top bits from open bus
    wr(16'h2006, 8'h3F);
    wr(16'h2006, 8'hC0);
    rd(16'h2007, 8'hFC, "rd2007_palette");

    // $2005 with w reset by a $2002 read between writes
    wr(16'h2005, 8'h7D);
    rd(16'h2002, 8'h1D, "status_openbus");
    wr(16'h2005, 8'h7D);
    wr(16'h2005, 8'h5E);
    chkv("t_after_2005", 2, 0, 16'h6D6F);
    chkv("fine_x_5", 3, 0, 5);
    chkv("ctrl_mirror_t", 7, 0, 8'h07);

    // Vblank with NMI enabled, then suppression
    wr(16'h2000, 8'h80);
    vblank = 1'b1;
    chkv("nmi_edge_cycle", 4, 0, 1);
    chkv("nmi_asserted", 4, 0, 0);
    rd(16'h2002, 8'h80, "status_vblank");
    chkv("nmi_cleared", 4, 0, 1);
    vblank = 1'b0;
    tick(); tick();
    vblank = 1'b1;
    rd(16'h2002, 8'h00, "status_suppressed");
    chkv("nmi_suppressed", 4, 0, 1);
    rd(16'h2002, 8'h00, "flag_stays_0");
    vblank = 1'b0;
    tick();

    // Enabling NMI while F=1
    wr(16'h2000, 8'h00);
    vblank = 1'b1;
    tick(); tick();
    chkv("nmi_disabled", 4, 0, 1);
    wr(16'h2000, 8'h80);
    chkv("nmi_late_enable", 4, 0, 0);
    rd(16'h2002, 8'h80, "status_late");
    vblank = 1'b0;
    wr(16'h2000, 8'h00);

    // DMA at even parity with ignored accesses during halt
    wr(16'h2003, 8'h10);
    if (p) tick();
    hbase = hcnt;
    wr(16'h4014, 8'h02);
    wr(16'h2003, 8'h55);
    rd(16'h2002, 8'h00, "rd_during_halt");
    wr(16'h4014, 8'h07);
    wait_dma_done();
    chkv("dma_len_even", 9, 0, 513);
    chkv("oamaddr_end", 6, 0, 8'h10);
    chkv("oam_10", 10, 8'h10, 8'hA5);
    chkv("oam_11", 10, 8'h11, 8'hA4);
    chkv("oam_0f", 10, 8'h0F, 8'h5A);

    // DMA at odd parity
    if (!p) tick();
    hbase = hcnt;
    wr(16'h4014, 8'h02);
    wait_dma_done();
    chkv("dma_len_odd", 9, 0, 514);
    chkv("oamaddr_end_odd", 6, 0, 8'h10);

    // Reset mid-DMA, then a complete transfer
    if (p) tick();
    wr(16'h4014, 8'h02);
    repeat (100) tick();
    rstn = 1'b0;
    #1;
    chkv("halt_async_drop", 5, 0, 0);
    chkv("oamaddr_rst", 6, 0, 0);
    rstn = 1'b1;
    chkv("halt_after_rst", 5, 0, 0);
    if (p) tick();
    hbase = hcnt;
    wr(16'h4014, 8'h02);
    wait_dma_done();
    chkv("dma_len_after_rst", 9, 0, 513);
    chkv("oam_ff", 10, 8'hFF, 8'h5A);
    chkv("oam_80", 10, 8'h80, 8'h25);
    chkv("oamaddr_wrap", 6, 0, 0);

    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppu_regif.md
# ppu_regif

CPU-side register interface for the PPU: a parametrised successor to the existing PPU config block. It decodes $2000–$2007 (mirrored through $3FFF) and $4014. It keeps the full loopy T/V/fine-X/write-toggle state, an open-bus latch, a vblank flag with read-clear and suppression, and a level-correct NMI. It adds an OAM DMA engine that halts the CPU and copies one CPU page into OAM. It sits between the CPU bus and the PPU render core and OAM/VRAM arbiters.

## Interface
- VADDR_W, 14, VRAM address width driven on o_vram_addr (≤15)
- OAM_AW, 8, OAM address width; OAMADDR wraps mod 2^OAM_AW
- DMA_EN, 1, 1 = $4014 DMA engine present; 0 = $4014 writes ignored, o_dma_halt tied 0
- i_cpu_clk  in  1  CPU clock
- i_cpu_rstn  in  1  reset i_cpu_rstn, asynchronous, active-low
- i_bus_valid  in  1  one-cycle access strobe; address/data valid this cycle
- i_bus_addr  in  16  CPU address
- i_bus_wn  in  1  0 = write, 1 = read
- i_bus_wdata  in  8  write data
- o_ppu_rdata  out  8  read data, combinational in the access cycle; 0 when not decoded
- o_dma_halt  out  1  CPU stall request
- o_dma_addr  out  16  DMA source address
- i_dma_rdata  in  8  DMA read data, valid the cycle after o_dma_addr
- o_oam_addr  out  OAM_AW  OAM address
- o_oam_we  out  1  OAM write strobe
- o_oam_wdata  out  8  OAM write data
- i_oam_rdata  in  8  OAM read data
- o_vram_addr  out  VADDR_W  loopy V low bits
- o_vram_we  out  1  VRAM write strobe
- o_vram_wdata  out  8  VRAM write data
- i_vram_rdata  in  8  VRAM read data
- o_2007_visit  out  1  $2007 access this cycle
- o_ppuctrl  out  8  PPUCTRL; bits [1:0] mirror T[11:10]
- o_ppumask  out  8  PPUMASK
- o_loopy_t  out  15  loopy T
- o_fine_x  out  3  fine X
- o_force_rld  out  1  one-cycle pulse when V is reloaded from T
- i_spr_ovfl  in  1  sprite overflow status
- i_spr_0hit  in  1  sprite-0 hit status
- i_vblank  in  1  vblank level from the render core
- o_nmi_n  out  1  NMI, active low

## Operation
- Register decode: PPU registers when addr[15:13]==3'b001, register index addr[2:0]. DMA register when addr==16'h4014. Side effects only when i_bus_valid=1 and o_dma_halt=0.
- Open-bus latch L[7:0]: loaded on every PPU write.
- $2000 write:
  - CTRL ← d.
  - T[11:10] ← d[1:0].
- $2001 write: MASK ← d.
- $2003 write: OAMADDR ← d.
- $2004:
  - Write: o_oam_we=1 and OAMADDR increments.
  - Read: returns i_oam_rdata; no increment.
- $2005, first write (w=0):
  - T[4:0] ← d[7:3].
  - fine X ← d[2:0].
- $2005, second write (w=1):
  - T[9:5] ← d[7:3].
  - T[14:12] ← d[2:0].
- $2006, first write (w=0): T[13:8] ← d[5:0], T[14] ← 0.
- $2006, second write (w=1):
  - T[7:0] ← d.
  - V ← {T[14:8], d}.
  - o_force_rld pulses.
- Write toggle w: each $2005/$2006 write toggles w.
- $2007 (any access):
  - V increments by 32 if CTRL[2], else by 1, mod 2^15.
  - Write: o_vram_we=1.
  - Read: returns buffer B, or {L[7:6], i_vram_rdata[5:0]} when V[13:8]==6'h3F.
  - Read: B ← i_vram_rdata.
- $2002 read:
  - Returns {F, i_spr_0hit, i_spr_ovfl, L[4:0]}.
  - Clears F and w the next cycle.
- Reads of write-only registers return L.
- Vblank flag F:
  - Set on the rising edge of i_vblank (registered edge detect).
  - Cleared on a $2002 read or on the falling edge of i_vblank.
  - Rising edge in the same cycle as a $2002 read: the read returns F=0 and F stays 0 (suppression).
- NMI: o_nmi_n = ~(F & CTRL[7]). Setting CTRL[7] while F=1 asserts NMI immediately.
- DMA FSM (DMA_EN=1), states IDLE → HALT → [ALIGN] → RD ↔ WR → IDLE:
  - A $4014 write latches page P and moves IDLE → HALT.
  - ALIGN is entered only if the free-running cycle parity bit was 1 at the $4014 write.
  - RD: o_dma_addr={P, cnt}.
  - WR: o_oam_we=1, o_oam_wdata=i_dma_rdata, OAMADDR increments, cnt increments.
  - WR with cnt==255 → IDLE.
- OAM write-data mux: o_oam_wdata = i_bus_wdata outside DMA.
- Reset: all registers, T, V, w, B, L, F, cnt and P are 0; FSM is IDLE.
- Reset values of outputs:
  - o_nmi_n=1.
  - o_dma_halt, o_oam_we, o_vram_we, o_force_rld and o_2007_visit are 0.
  - All other outputs are 0.
- Reset mid-DMA aborts the transfer immediately; o_dma_halt drops asynchronously.

## Timing
- Register writes take effect at the clock edge ending the access cycle.
- Strobes o_oam_we, o_vram_we and o_2007_visit are combinational in the access cycle.
- o_force_rld is high during the second $2006 write cycle.
- o_dma_halt is high from the cycle after the $4014 write through the final WR cycle.
- DMA duration: 513 cycles at even parity, 514 at odd.
- Bus accesses during halt are ignored; a $4014 write while busy is ignored.
- F and NMI update 1 cycle after the i_vblank edge.

## Test plan
- Write $2006=$21, $2006=$08:
  - V=$2108, o_force_rld pulses once.
  - Then $2007 reads with CTRL[2]=1 give V=$2128, $2148.
  - Each read returns the previous buffer value.
- Write $2005=$7D, $2005=$5E: T[4:0]=$0F, fine X=5, T[9:5]=$0B, T[14:12]=6. A $2002 read between the two writes resets w.
- i_vblank rise with CTRL[7]=1:
  - o_nmi_n=0 next cycle.
  - $2002 read returns bit7=1, then o_nmi_n=1.
  - A rise coincident with a $2002 read gives bit7=0 and no NMI.
- With F=1 and CTRL=0, write CTRL=$80: o_nmi_n goes 0 the cycle after the write.
- DMA from page $02 (memory model byte=addr[7:0]^$A5), OAMADDR=$10:
  - o_dma_halt lasts 513 cycles at even parity, 514 at odd.
  - OAM[($10+n)&$FF]=n^$A5.
  - OAMADDR ends at $10.
- Assert reset at DMA cycle 100: o_dma_halt=0 and the FSM is IDLE. A later $4014 write completes normally.
